// File: rtl/coeff_loader.sv
// rtl/coeff_loader.sv - serial-to-parallel loader for the rj and coefficient tables
//
// Purpose:
//   Assembles framed, MSB-first serial words (one bit per bit_en strobe) and
//   writes them first into the rj memory (RJ_N words), then into the coeff
//   memory (COEFF_N words). Coefficient words are passed through untouched.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   start      begins a load sequence from IDLE or DONE, ignored otherwise
//   bit_en     data_in/frame valid this cycle
//   frame      high with the MSB of each word
//   data_in    serial data bit
//   rj_we      one-cycle write strobe to the rj memory
//   coeff_we   one-cycle write strobe to the coeff memory
//   waddr      word index within the current table
//   wdata      assembled word, first received bit at wdata[WORD_W-1]
//   busy       loading rj or coeff words
//   done       whole sequence loaded, held until start or rst
//   frame_err  one-cycle pulse when frame arrives in the middle of a word
module coeff_loader #(
  parameter int WORD_W  = 16,
  parameter int RJ_N    = 16,
  parameter int COEFF_N = 512,
  parameter int ADDR_W  = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              bit_en,
  input  logic              frame,
  input  logic              data_in,
  output logic              rj_we,
  output logic              coeff_we,
  output logic [ADDR_W-1:0] waddr,
  output logic [WORD_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              frame_err
);

  localparam int BIT_W = $clog2(WORD_W);
  localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(WORD_W - 1);
  localparam logic [ADDR_W-1:0] RJ_LAST    = ADDR_W'(RJ_N - 1);
  localparam logic [ADDR_W-1:0] COEFF_LAST = ADDR_W'(COEFF_N - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD_RJ    = 2'd1,
    LOAD_COEFF = 2'd2,
    DONE       = 2'd3
  } state_t;

  state_t state, state_n;

  logic [BIT_W-1:0]  bit_cnt;
  logic [ADDR_W-1:0] word_cnt;
  // Only WORD_W-1 bits are kept: the LSB goes straight into wdata.
  logic [WORD_W-2:0] shift_q;

  logic loading;
  logic bit_take;
  logic msb_bit;
  logic err_bit;
  logic mid_bit;
  logic lsb_bit;
  logic table_end;
  logic start_ok;

  always_comb begin
    loading   = (state == LOAD_RJ) || (state == LOAD_COEFF);
    bit_take  = loading && bit_en;
    // A frame bit always starts a new word; if a word was in progress that
    // is a framing error and the partial word is dropped.
    msb_bit   = bit_take && frame && (bit_cnt == '0);
    err_bit   = bit_take && frame && (bit_cnt != '0);
    mid_bit   = bit_take && !frame && (bit_cnt != '0) && (bit_cnt != BIT_LAST);
    lsb_bit   = bit_take && !frame && (bit_cnt == BIT_LAST);
    table_end = (state == LOAD_RJ) ? (word_cnt == RJ_LAST) : (word_cnt == COEFF_LAST);
    start_ok  = start && ((state == IDLE) || (state == DONE));

    state_n = state;
    case (state)
      IDLE:       if (start) state_n = LOAD_RJ;
      LOAD_RJ:    if (lsb_bit && table_end) state_n = LOAD_COEFF;
      LOAD_COEFF: if (lsb_bit && table_end) state_n = DONE;
      DONE:       if (start) state_n = LOAD_RJ;
      default:    state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      word_cnt  <= '0;
      shift_q   <= '0;
      rj_we     <= 1'b0;
      coeff_we  <= 1'b0;
      waddr     <= '0;
      wdata     <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      rj_we     <= 1'b0;
      coeff_we  <= 1'b0;
      frame_err <= err_bit;

      if (start_ok) begin
        bit_cnt  <= '0;
        word_cnt <= '0;
        shift_q  <= '0;
      end else if (msb_bit || err_bit) begin
        shift_q <= {{(WORD_W-2){1'b0}}, data_in};
        bit_cnt <= BIT_W'(1);
      end else if (mid_bit) begin
        shift_q <= {shift_q[WORD_W-3:0], data_in};
        bit_cnt <= bit_cnt + BIT_W'(1);
      end else if (lsb_bit) begin
        // Word complete: the strobe, address and data all appear on the
        // next cycle, while the next word's MSB may already be arriving.
        bit_cnt  <= '0;
        rj_we    <= (state == LOAD_RJ);
        coeff_we <= (state == LOAD_COEFF);
        waddr    <= word_cnt;
        wdata    <= {shift_q, data_in};
        word_cnt <= table_end ? '0 : word_cnt + ADDR_W'(1);
      end
    end
  end

  assign busy = loading;
  assign done = (state == DONE);

endmodule

// File: tb/tb_coeff_loader.sv
// tb/tb_coeff_loader.sv - self-checking bench for coeff_loader
module tb_coeff_loader;

  logic        clk = 1'b0;
  logic        rst, start, bit_en, frame, data_in;
  logic        rj_we, coeff_we, busy, done, frame_err;
  logic [8:0]  waddr;
  logic [15:0] wdata;

  coeff_loader #(.WORD_W(16), .RJ_N(16), .COEFF_N(512), .ADDR_W(9)) dut (
    .clk(clk), .rst(rst), .start(start), .bit_en(bit_en), .frame(frame),
    .data_in(data_in), .rj_we(rj_we), .coeff_we(coeff_we), .waddr(waddr),
    .wdata(wdata), .busy(busy), .done(done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  // Observed writes and frame errors
  typedef struct {
    logic        c;
    logic [8:0]  a;
    logic [15:0] d;
    int          cy;
    logic        bsy;
    logic        dn;
  } wr_t;

  wr_t wr_q[$];
  wr_t exp_q[$];
  int  ferr_cnt = 0;
  int  exp_ferr = 0;

  always @(negedge clk) begin
    if (rj_we || coeff_we) wr_q.push_back('{coeff_we, waddr, wdata, cyc, busy, done});
    if (frame_err) ferr_cnt++;
  end

  // Reference model: clean words fill rj slots 0..15 then coeff slots 0..511
  int m_rj, m_cf;

  function automatic void model_start();
    m_rj = 0;
    m_cf = 0;
  endfunction

  function automatic void model_word(input logic [15:0] w, input int c);
    if (m_rj < 16) begin
      exp_q.push_back('{1'b0, 9'(m_rj), w, c, 1'b1, 1'b0});
      m_rj++;
    end else if (m_cf < 512) begin
      exp_q.push_back('{1'b1, 9'(m_cf), w, c, (m_cf != 511), (m_cf == 511)});
      m_cf++;
    end
  endfunction

  task automatic compare_writes(input string nm);
    wr_t e, a;
    int  i;
    chk({nm, "_count"}, wr_q.size(), exp_q.size());
    i = 0;
    while (exp_q.size() > 0 && wr_q.size() > 0) begin
      e = exp_q.pop_front();
      a = wr_q.pop_front();
      chk($sformatf("%s_wr[%0d]", nm, i), {4'b0, a.c, a.a, a.d, a.bsy, a.dn},
          {4'b0, e.c, e.a, e.d, e.bsy, e.dn});
      chk($sformatf("%s_cyc[%0d]", nm, i), a.cy, e.cy);
      i++;
    end
    exp_q.delete();
    wr_q.delete();
  endtask

  // Stimulus helpers; all called at #1 after a rising edge
  int last_cyc;

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive_bit(input logic f, input logic d);
    bit_en = 1'b1; frame = f; data_in = d;
    last_cyc = cyc;
    @(posedge clk); #1;
    bit_en = 1'b0; frame = 1'b0; data_in = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input int gap);
    for (int k = 0; k < 16; k++) begin
      drive_bit(k == 0, w[15-k]);
      idle(gap);
    end
    model_word(w, last_cyc + 1);
  endtask

  task automatic send_partial(input logic [15:0] w, input int len);
    for (int k = 0; k < len; k++) drive_bit(k == 0, w[15-k]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    idle(1);
    start = 1'b0;
  endtask

  // Cycle-level vectors: inputs applied for one cycle, outputs checked after the edge
  typedef struct {
    logic rst, start, be, fr, d;
    logic [3:0] exp;  // {busy, done, frame_err, any_we}
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [15:0] w;
    int len;

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0000};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1000};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1000};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1010};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1000};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000};

    rst = 1'b1; start = 1'b0; bit_en = 1'b0; frame = 1'b0; data_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 32'({rj_we, coeff_we, waddr, wdata, busy, done, frame_err}), 32'd0);

    for (int i = 0; i < 12; i++) begin
      rst = vecs[i].rst; start = vecs[i].start; bit_en = vecs[i].be;
      frame = vecs[i].fr; data_in = vecs[i].d;
      @(posedge clk); #1;
      chk($sformatf("vec[%0d]_status", i),
          32'({busy, done, frame_err, rj_we | coeff_we}), 32'(vecs[i].exp));
      chk($sformatf("vec[%0d]_bus", i), 32'({waddr, wdata}), 32'd0);
    end
    rst = 1'b0; start = 1'b0; bit_en = 1'b0; frame = 1'b0; data_in = 1'b0;
    idle(1);
    chk("vec_no_writes", wr_q.size(), 0);
    chk("vec_ferr_count", ferr_cnt, 1);
    wr_q.delete();
    ferr_cnt = 0;

    // Full load, bit_en every 4th cycle
    pulse_start();
    model_start();
    for (int i = 0; i < 16; i++) send_word(16'h0020, 3);
    send_word(16'h00BF, 3);
    send_word(16'h015A, 3);
    send_word(16'h01CE, 3);
    for (int i = 3; i < 512; i++) send_word(16'($urandom), 3);
    idle(3);
    compare_writes("full");
    chk("full_done", 32'(done), 32'd1);
    chk("full_busy", 32'(busy), 32'd0);
    chk("full_ferr", ferr_cnt, exp_ferr);

    // Reload from DONE, back-to-back bits
    start = 1'b1;
    idle(1);
    start = 1'b0;
    chk("reload_done_clear", 32'({done, busy}), 32'b01);
    model_start();
    for (int i = 0; i < 16; i++) send_word(16'h0011, 0);
    // Start during LOAD_COEFF, held across a whole word, must not disturb anything
    start = 1'b1;
    idle(1);
    start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (i == 50) start = 1'b1;
      send_word(16'($urandom), $urandom_range(0, 1));
      start = 1'b0;
    end
    idle(2);
    compare_writes("reload");

    // Reset across the tail of coeff word 100 and the cycle after its LSB
    w = 16'($urandom);
    send_partial(w, 12);
    rst = 1'b1;
    for (int k = 12; k < 16; k++) drive_bit(1'b0, w[15-k]);
    idle(2);
    rst = 1'b0;
    idle(1);
    chk("rst_no_write", wr_q.size(), 0);
    chk("rst_outputs", 32'({rj_we, coeff_we, waddr, wdata, busy, done, frame_err}), 32'd0);
    wr_q.delete();

    // Restart from IDLE: back-to-back words, then a framing error on rj word 3
    pulse_start();
    model_start();
    send_word(16'hA5A5, 0);
    send_word(16'h5A5A, 0);
    send_word(16'($urandom), 1);
    send_partial(16'hFFFF, 8);
    send_word(16'h1234, 0);
    exp_ferr++;
    idle(2);
    compare_writes("frame");
    chk("frame_ferr", ferr_cnt, exp_ferr);

    // Randomised traffic: idle bits, gaps, aborted words
    for (int i = 0; i < 52; i++) begin
      repeat ($urandom_range(0, 2)) drive_bit(1'b0, 1'($urandom));
      if ($urandom_range(0, 7) == 0) begin
        len = $urandom_range(1, 15);
        send_partial(16'($urandom), len);
        exp_ferr++;
      end
      send_word(16'($urandom), $urandom_range(0, 3));
    end
    idle(3);
    compare_writes("rand");
    chk("rand_ferr", ferr_cnt, exp_ferr);
    chk("rand_busy", 32'({busy, done}), 32'b10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/coeff_loader.md
Name: coeff_loader

Overview:
- Serial-to-parallel loader that fills the filter's rj table and coefficient table.
- Serial words arrive MSB first, framed, one bit per bit_en strobe. The loader assembles them and issues single-cycle write strobes into the rj memory (16 entries) and the coeff memory (512 entries).
- It is the write-side counterpart of the table ROM that streams these values out to the datapath.

Parameters:
- WORD_W, 16, serial word width in bits.
- RJ_N, 16, number of rj words loaded first.
- COEFF_N, 512, number of coefficient words loaded after the rj words.
- ADDR_W, 9, write address width; must satisfy 2**ADDR_W >= max(RJ_N, COEFF_N).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load sequence; ignored unless state is IDLE or DONE.
- bit_en  input  1  one-cycle strobe meaning data_in and frame are valid this cycle (serial-clock edge detected upstream).
- frame  input  1  qualified by bit_en; high marks the MSB of a word.
- data_in  input  1  serial data bit, qualified by bit_en.
- rj_we  output  1  one-cycle write strobe to the rj memory.
- coeff_we  output  1  one-cycle write strobe to the coeff memory.
- waddr  output  ADDR_W  write address: word index within the current table.
- wdata  output  WORD_W  assembled word.
- busy  output  1  high in LOAD_RJ or LOAD_COEFF.
- done  output  1  high in DONE; sticky until start or rst.
- frame_err  output  1  one-cycle pulse on a framing violation.

Behaviour:
- Reset values: rj_we=0, coeff_we=0, waddr=0, wdata=0, busy=0, done=0, frame_err=0, state=IDLE, bit_cnt=0, word_cnt=0, shift register=0.
- States:
  - IDLE: start -> LOAD_RJ with word_cnt=0, bit_cnt=0.
  - LOAD_RJ: after the RJ_N-th word is written -> LOAD_COEFF with word_cnt=0.
  - LOAD_COEFF: after the COEFF_N-th word is written -> DONE.
  - DONE: start -> LOAD_RJ (reload).
- Bit capture, only in LOAD_* states and only on a cycle with bit_en=1:
  - bit_cnt==0 with frame=1: shift data_in in as the MSB; bit_cnt=1.
  - bit_cnt==0 with frame=0: idle bit, ignored.
  - 0 < bit_cnt < WORD_W-1: shift data_in in; bit_cnt+1.
  - bit_cnt==WORD_W-1: shift in the LSB; bit_cnt=0; word complete.
- Write timing: on the cycle after the LSB capture, exactly one of rj_we/coeff_we is high for one cycle.
  - waddr = word_cnt; wdata = assembled word with the first-received bit at wdata[WORD_W-1].
  - word_cnt increments on that same edge.
  - waddr and wdata hold their last values when no strobe is active.
- Coefficient words: all WORD_W bits are passed unmodified. Bit 8 is the sign and bits 7:0 the shift index; interpretation belongs to the datapath.
- Framing error: bit_en with frame=1 while bit_cnt != 0:
  - frame_err pulses on the next cycle.
  - The partial word is discarded and no write is issued.
  - The current bit is taken as the MSB of a new word (bit_cnt=1).
  - word_cnt is unchanged.
- start while busy: ignored, with no effect on any counter.
- bit_en in IDLE or DONE: ignored; no writes, no frame_err.
- busy drops on the same edge that issues the final coeff_we. done rises on that same edge.
- rst mid-load: the next cycle is in the reset state. A write strobe pending from the final bit is cancelled.
- Simultaneous start and rst: rst wins.
- Maximum throughput: bit_en may be high every cycle. The write of word N overlaps the capture of word N+1's MSB without loss.

Test Plan:
1. Full load, normal order:
   - Stimulus: rst, then start; 16 rj words of 0x0020, then 512 coeff words 0x00BF, 0x015A, 0x01CE, …, with bit_en every 4th cycle.
   - Required response: 16 rj_we pulses with waddr 0..15 and wdata=0x0020. 512 coeff_we pulses with waddr 0..511; the first three wdata are 0x00BF, 0x015A, 0x01CE. done=1 on the last write; busy=0 after it.
2. Back-to-back bits:
   - Stimulus: bit_en held high continuously; words 0xA5A5 then 0x5A5A.
   - Required response: rj_we exactly 1 cycle after each LSB; wdata=0xA5A5 then 0x5A5A; no bits lost.
3. Framing error:
   - Stimulus: frame=1 re-asserted on bit 7 of rj word 3, then a clean word 0x1234.
   - Required response: one frame_err pulse; no write for the corrupted word; next write has waddr=3 and wdata=0x1234.
4. Reset mid-load:
   - Stimulus: assert rst during coeff word 100, including on the cycle after its LSB.
   - Required response: no coeff_we for that word; all outputs return to 0; a subsequent start reloads from rj waddr=0.
5. Ignored inputs:
   - Stimulus: bit_en/frame traffic in IDLE; start issued during LOAD_COEFF.
   - Required response: no we pulses in IDLE; the start during LOAD_COEFF does not alter word_cnt (next waddr continues in sequence).
6. Reload from DONE:
   - Stimulus: start in DONE, then 16 rj words of 0x0011.
   - Required response: done clears on the cycle after start; rj_we pulses at waddr 0..15 with wdata=0x0011.
